// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, execute-stage redirect
// and the instruction-register handshake towards the decoder.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic [31:0]       ir_instr;
  logic [7:0]        ir_opcode;
  logic [ADDR_W-1:0] ir_pc;
  logic [ADDR_W-1:0] ir_pc_plus4;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid,
    input  redirect,
    input  redirect_pc,
    output ir_valid,
    input  ir_ready,
    output ir_instr,
    output ir_opcode,
    output ir_pc,
    output ir_pc_plus4
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid,
    output redirect,
    output redirect_pc,
    input  ir_valid,
    output ir_ready,
    input  ir_instr,
    input  ir_opcode,
    input  ir_pc,
    input  ir_pc_plus4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch, IR with
// valid/ready towards the decoder, redirect squashes wrong path.
// Ports: clk, rst (sync, active high), bus (fetch_unit_if.master).
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic              irv_q, irv_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] irpc_q, irpc_d;
  logic [ADDR_W-1:0] irpc4_q, irpc4_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic              capture;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  // A response in WAIT is only kept when no redirect
  // arrives in the same cycle.
  assign capture = (state_q == S_WAIT) &&
                   bus.imem_valid && !bus.redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    irv_d   = irv_q;
    instr_d = instr_q;
    irpc_d  = irpc_q;
    irpc4_d = irpc4_q;

    unique case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.imem_valid) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.ir_ready) begin
          irv_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (bus.imem_valid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      instr_d = bus.imem_rdata;
      irpc_d  = pc_q;
      irpc4_d = pc_plus4;
      irv_d   = 1'b1;
      pc_d    = pc_plus4;
    end

    // Redirect wins over everything; a request already
    // issued with the old pc must be drained first.
    if (bus.redirect) begin
      pc_d  = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      irv_d = 1'b0;
      unique case (state_q)
        S_REQ: state_d = S_DRAIN;
        S_WAIT,
        S_DRAIN: begin
          state_d = bus.imem_valid ? S_REQ : S_DRAIN;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign req_d = (state_d == S_REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      irv_q   <= 1'b0;
      instr_q <= '0;
      irpc_q  <= '0;
      irpc4_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      irv_q   <= irv_d;
      instr_q <= instr_d;
      irpc_q  <= irpc_d;
      irpc4_q <= irpc4_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.ir_valid    = irv_q;
  assign bus.ir_instr    = instr_q;
  assign bus.ir_opcode   = instr_q[31:24];
  assign bus.ir_pc       = irpc_q;
  assign bus.ir_pc_plus4 = irpc4_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the opcode decoder/control unit.
- Holds the PC and issues one word fetch at a time to instruction memory over a req/valid handshake.
- Captures each returned word into an instruction register and presents it downstream with a valid/ready handshake, together with the 8-bit opcode field and the PC values needed for branch and branch-and-link.
- Accepts redirects (taken branches, br, bl) from the execute stage and squashes any wrong-path fetch.

Parameters:
ADDR_W, 32, width of the PC and instruction-memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request strobe, one cycle per request
imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1, otherwise don't-care
imem_rdata  in  32  returned instruction word
imem_valid  in  1  imem_rdata valid this cycle; at most one response per request, arriving at least 1 cycle after the request
redirect  in  1  branch taken; load redirect_pc
redirect_pc  in  ADDR_W  branch target address
ir_valid  out  1  instruction register holds a valid instruction
ir_ready  in  1  downstream consumes the instruction this cycle
ir_instr  out  32  captured instruction word
ir_opcode  out  8  ir_instr[31:24], fed to the control decoder
ir_pc  out  ADDR_W  address the instruction was fetched from
ir_pc_plus4  out  ADDR_W  ir_pc+4, the link value for bl

Behaviour:
- Reset (rst=1 at a clock edge), from any state:
  - state=IDLE, pc=RESET_PC, imem_req=0, ir_valid=0.
  - ir_instr, ir_pc and ir_pc_plus4 cleared to 0.
  - Any outstanding fetch is abandoned.
- All outputs are registered; ir_opcode is a wire slice of ir_instr.
- FSM states:
  - IDLE: 1 cycle, then REQ. imem_valid is ignored.
  - REQ: imem_req=1, imem_addr=pc; the request is accepted this cycle. Next state WAIT.
  - WAIT: on imem_valid, load ir_instr=imem_rdata, ir_pc=pc, ir_pc_plus4=pc+4; set ir_valid=1 and pc<=pc+4; go to HOLD.
  - HOLD: ir_valid=1 and IR contents stable. If ir_ready=1, clear ir_valid and go to REQ.
  - DRAIN: a wrong-path response is outstanding. On imem_valid, discard the data and go to REQ.
- Latency and throughput:
  - Request is issued 1 cycle after leaving IDLE/HOLD.
  - ir_valid rises on the edge after imem_valid.
  - With 1-cycle memory, one instruction per 3 cycles.
- Redirect (redirect=1) is sampled every cycle and takes priority over all other events:
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; low bits are forced to 0.
  - ir_valid <= 0; an instruction held in HOLD is squashed even if ir_ready=1 the same cycle.
  - Next state:
    - from IDLE or HOLD: REQ.
    - from REQ: DRAIN (the request went out with the old pc).
    - from WAIT: DRAIN, or REQ if imem_valid arrives the same cycle (that response is dropped).
    - from DRAIN: stays DRAIN, or REQ if imem_valid arrives the same cycle.
- PC arithmetic: +4 modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0x0000_0000. ir_pc_plus4 wraps the same way.
- imem_valid outside WAIT/DRAIN is a protocol error and is ignored; no state change.
- Never more than one outstanding request: imem_req=1 only in REQ.
- Reset mid-operation (e.g. during WAIT): returns to IDLE; a response arriving afterwards is ignored because the FSM is in IDLE or REQ.

Test Plan:
- Reset then free-run:
  - Setup: rst high 2 cycles, 1-cycle memory returning addr^32'hA5A5_0000, ir_ready tied 1.
  - Response: imem_addr sequence 0x0, 0x4, 0x8; ir_pc/ir_pc_plus4 = 0/4, 4/8; ir_opcode = imem_rdata[31:24]; one instruction every 3 cycles.
- Downstream stall:
  - Stimulus: hold ir_ready=0 for 5 cycles with an instruction valid.
  - Response: ir_valid stays 1, IR unchanged, imem_req stays 0; one cycle after ir_ready=1, imem_req=1 with addr=ir_pc+4.
- Redirect in WAIT:
  - Stimulus: 3-cycle memory; redirect=1, redirect_pc=0x0000_0102 while waiting on 0x8.
  - Response: the 0x8 response is discarded (ir_valid stays 0); next imem_addr=0x0000_0100.
- Simultaneous events:
  - Redirect with imem_valid in WAIT: data dropped, next state REQ at the target.
  - Redirect with ir_ready in HOLD: instruction squashed, next request at the target.
- Wrap-around:
  - Stimulus: RESET_PC=32'hFFFF_FFFC.
  - Response: first ir_pc_plus4=0; second fetch address 0x0.
- Reset mid-fetch:
  - Stimulus: assert rst in WAIT, then deliver imem_valid one cycle after rst falls.
  - Response: ir_valid=0, the response is ignored, the first request is to RESET_PC.
